// File: rtl/output_arbiter.sv
// Round-robin arbiter for four requesters that share one 8-bit output register.
// Optional HOLD phase after each write is enabled by defining OUTPUT_ARBITER_HOLD_EN.
module output_arbiter #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic        reg_clk,
  input  logic        reg_rst_n,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  output logic [3:0]  ack,
  output logic [7:0]  out_data,
  output logic        out_en,
  output logic [1:0]  grant_id,
  output logic        busy
);

`ifdef OUTPUT_ARBITER_HOLD_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    HOLD  = 2'd2
  } state_t;
`else
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;
`endif

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_last;
  logic [1:0]  w_last_nxt;
  logic [7:0]  r_data;
  logic [7:0]  w_data_nxt;
  logic        r_en;
  logic        w_en_nxt;
  logic [3:0]  r_ack;
  logic [3:0]  w_ack_nxt;
  logic [1:0]  r_gid;
  logic [1:0]  w_gid_nxt;
  logic        r_busy;
  logic        w_busy_nxt;
  logic [1:0]  w_win;
`ifdef OUTPUT_ARBITER_HOLD_EN
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_nxt;
`endif

  // Walk last+4 down to last+1 so the nearest requester after last wins.
  always_comb begin
    w_win = r_last;
    for (int k = 4; k >= 1; k--) begin
      if (req[r_last + k[1:0]])
        w_win = r_last + k[1:0];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_data_nxt  = r_data;
    w_en_nxt    = 1'b0;
    w_ack_nxt   = 4'b0000;
    w_gid_nxt   = r_gid;
`ifdef OUTPUT_ARBITER_HOLD_EN
    w_cnt_nxt   = r_cnt;
`endif
    unique case (r_state)
      IDLE: begin
        if (|req) begin
          w_state_nxt = WRITE;
          w_last_nxt  = w_win;
          w_data_nxt  = req_data[{w_win, 3'b000} +: 8];
          w_en_nxt    = 1'b1;
          w_ack_nxt   = 4'b0001 << w_win;
          w_gid_nxt   = w_win;
        end
      end
      WRITE: begin
`ifdef OUTPUT_ARBITER_HOLD_EN
        w_state_nxt = HOLD;
        w_cnt_nxt   = 8'(HOLD_CYCLES);
`else
        w_state_nxt = IDLE;
`endif
      end
`ifdef OUTPUT_ARBITER_HOLD_EN
      HOLD: begin
        w_cnt_nxt = r_cnt - 8'd1;
        if (r_cnt <= 8'd1) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 8'd0;
        end
      end
`endif
      default: w_state_nxt = IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != IDLE);
  end

  always_ff @(posedge reg_clk) begin
    if (!reg_rst_n) begin
      r_state <= IDLE;
      r_last  <= 2'd3;
      r_data  <= 8'h00;
      r_en    <= 1'b0;
      r_ack   <= 4'b0000;
      r_gid   <= 2'd0;
      r_busy  <= 1'b0;
`ifdef OUTPUT_ARBITER_HOLD_EN
      r_cnt   <= 8'd0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_data  <= w_data_nxt;
      r_en    <= w_en_nxt;
      r_ack   <= w_ack_nxt;
      r_gid   <= w_gid_nxt;
      r_busy  <= w_busy_nxt;
`ifdef OUTPUT_ARBITER_HOLD_EN
      r_cnt   <= w_cnt_nxt;
`endif
    end
  end

  assign ack      = r_ack;
  assign out_data = r_data;
  assign out_en   = r_en;
  assign grant_id = r_gid;
  assign busy     = r_busy;

endmodule

// File: tb/tb_output_arbiter.sv
// Bench for output_arbiter: directed scenarios plus random traffic,
// every cycle compared against a grant-timeline model.
module tb_output_arbiter;

  localparam int HOLD = 4;
`ifdef OUTPUT_ARBITER_HOLD_EN
  localparam int P = HOLD + 2;
`else
  localparam int P = 2;
`endif

  logic        reg_clk;
  logic        reg_rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [7:0]  out_data;
  logic        out_en;
  logic [1:0]  grant_id;
  logic        busy;

  output_arbiter #(.HOLD_CYCLES(HOLD)) dut (
    .reg_clk   (reg_clk),
    .reg_rst_n (reg_rst_n),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .out_data  (out_data),
    .out_en    (out_en),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  initial begin
    reg_clk = 1'b0;
    forever #5 reg_clk = ~reg_clk;
  end

  int n_tot = 0;
  int n_bad = 0;

  int         m_left;
  int         m_last;
  logic [7:0] m_data;
  logic [1:0] m_gid;
  logic       m_en;
  logic [3:0] m_ack;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: a grant opens a busy window of P-1 cycles; the window
  // counts down and arbitration happens only once it has closed.
  task automatic model_step(input logic rst_n, input logic [3:0] rq,
                            input logic [31:0] d);
    int w;
    bit found;
    if (!rst_n) begin
      m_left = 0;
      m_last = 3;
      m_data = 8'h00;
      m_gid  = 2'd0;
      m_en   = 1'b0;
      m_ack  = 4'b0000;
    end else begin
      m_en  = 1'b0;
      m_ack = 4'b0000;
      if (m_left == 0) begin
        found = 1'b0;
        w = 0;
        for (int k = 1; k <= 4; k++) begin
          if (!found && rq[(m_last + k) % 4]) begin
            w = (m_last + k) % 4;
            found = 1'b1;
          end
        end
        if (found) begin
          m_last = w;
          m_gid  = 2'(w);
          m_data = d[8*w +: 8];
          m_en   = 1'b1;
          m_ack  = 4'(1 << w);
          m_left = P - 1;
        end
      end else begin
        m_left--;
      end
    end
  endtask

  task automatic compare_all();
    chk("ack", {28'd0, ack}, {28'd0, m_ack});
    chk("out_en", {31'd0, out_en}, {31'd0, m_en});
    chk("out_data", {24'd0, out_data}, {24'd0, m_data});
    chk("grant_id", {30'd0, grant_id}, {30'd0, m_gid});
    chk("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
  endtask

  task automatic cyc(input logic rst_n, input logic [3:0] rq,
                     input logic [31:0] d);
    reg_rst_n = rst_n;
    req       = rq;
    req_data  = d;
    @(posedge reg_clk);
    model_step(rst_n, rq, d);
    @(negedge reg_clk);
    compare_all();
  endtask

  int gt[$];
  int gv[$];
  int nb;
  logic [3:0]  rq;
  logic [31:0] rd;
  logic        rr;

  initial begin
    reg_rst_n = 1'b0;
    req       = 4'b0000;
    req_data  = 32'h0;
    @(negedge reg_clk);

    // Reset values
    cyc(1'b0, 4'b0000, 32'h0);
    cyc(1'b0, 4'b1111, 32'hFFFF_FFFF);
    chk("rst_out_data", {24'd0, out_data}, 32'h00);
    chk("rst_out_en", {31'd0, out_en}, 32'd0);
    chk("rst_ack", {28'd0, ack}, 32'd0);
    chk("rst_gid", {30'd0, grant_id}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // Single request from requester 2
    cyc(1'b1, 4'b0100, 32'h00A5_0000);
    chk("s26_en", {31'd0, out_en}, 32'd1);
    chk("s26_ack", {28'd0, ack}, 32'b0100);
    chk("s26_data", {24'd0, out_data}, 32'hA5);
    chk("s26_gid", {30'd0, grant_id}, 32'd2);
    nb = 0;
    for (int c = 0; c < 300 && busy; c++) begin
      nb++;
      cyc(1'b1, 4'b0000, 32'h5A5A_5A5A);
    end
    chk("s26_busy_len", nb, P - 1);
    chk("s26_data_kept", {24'd0, out_data}, 32'hA5);
    chk("s26_en_low", {31'd0, out_en}, 32'd0);

    // All requesting: strict rotation from requester 0
    cyc(1'b0, 4'b0000, 32'h0);
    gt.delete();
    gv.delete();
    for (int c = 0; c < 5 * P; c++) begin
      cyc(1'b1, 4'b1111, 32'h4433_2211);
      if (out_en) begin
        gt.push_back(c);
        gv.push_back(int'(grant_id));
      end
    end
    chk("s27_cnt", gv.size(), 5);
    for (int i = 0; i < gv.size() && i < 5; i++)
      chk("s27_gid", gv[i], i % 4);
    for (int i = 1; i < gt.size(); i++)
      chk("s27_gap", gt[i] - gt[i-1], P);

    // After grant to 1, requester 3 precedes 1
    cyc(1'b0, 4'b0000, 32'h0);
    cyc(1'b1, 4'b0010, 32'hDDCC_BBAA);
    chk("s28_gid1", {30'd0, grant_id}, 32'd1);
    gv.delete();
    for (int c = 0; c < 3 * P; c++) begin
      cyc(1'b1, 4'b1010, 32'hDDCC_BBAA);
      if (out_en) gv.push_back(int'(grant_id));
    end
    chk("s28_cnt", {31'd0, gv.size() >= 2}, 32'd1);
    if (gv.size() >= 2) begin
      chk("s28_first", gv[0], 3);
      chk("s28_second", gv[1], 1);
    end

    // Reset aborts an operation in progress
    cyc(1'b0, 4'b0000, 32'h0);
    cyc(1'b1, 4'b0010, 32'h0000_7700);
    cyc(1'b1, 4'b0000, 32'h0);
    cyc(1'b0, 4'b1111, 32'h0);
    chk("s29_busy", {31'd0, busy}, 32'd0);
    chk("s29_en", {31'd0, out_en}, 32'd0);
    chk("s29_ack", {28'd0, ack}, 32'd0);
    cyc(1'b1, 4'b1111, 32'h4433_2211);
    chk("s29_regrant", {30'd0, grant_id}, 32'd0);
    chk("s29_data", {24'd0, out_data}, 32'h11);

    // Random traffic
    rq = 4'b0000;
    rd = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      rr = ($urandom_range(199) != 0);
      for (int i = 0; i < 4; i++) begin
        if (rq[i]) begin
          if ((ack[i] && $urandom_range(1) == 0) || $urandom_range(29) == 0)
            rq[i] = 1'b0;
        end else if ($urandom_range(3) == 0) begin
          rq[i] = 1'b1;
          rd[8*i +: 8] = 8'($urandom);
        end
      end
      cyc(rr, rq, rd);
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/output_arbiter.md
OUTPUT_ARBITER -- requirements
Module: output_arbiter

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4, giving the cycles the written value is held before the next grant; legal range 1..255.
REQ-002 SHALL have port reg_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reg_rst_n  input  1  synchronous, active-low reset, sampled on the reg_clk rising edge.
REQ-004 SHALL have port req  input  4  request vector, one bit per requester 0..3.
REQ-005 SHALL have port req_data  input  32  requester i data on bits [8i+7:8i].
REQ-006 SHALL have port ack  output  4  one-cycle grant/acknowledge pulse per requester.
REQ-007 SHALL have port out_data  output  8  data to the downstream 8-bit output register.
REQ-008 SHALL have port out_en  output  1  write-enable pulse to the downstream output register.
REQ-009 SHALL have port grant_id  output  2  index of the most recent winner.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, WRITE and HOLD; all outputs registered, none combinational from inputs.
REQ-012 In IDLE with req != 0, SHALL select a winner, capture its req_data and enter WRITE at the next edge; in IDLE with req == 0, SHALL remain in IDLE.
REQ-013 Arbitration SHALL be round-robin: search order last+1, last+2, last+3, last (mod 4), where last is the previous winner.
REQ-014 In WRITE (exactly one cycle), out_en=1, ack[winner]=1, out_data=captured data and grant_id=winner, all simultaneously.
REQ-015 From WRITE, SHALL go to HOLD with counter loaded to HOLD_CYCLES; in HOLD, decrement each cycle and return to IDLE the cycle after the counter reaches 1.
REQ-016 Requests SHALL be ignored in WRITE and HOLD; a request dropped before its ack is never granted.
REQ-017 Latency SHALL be req sampled in IDLE at edge k -> out_en/ack high in cycle k+1; back-to-back grant period = HOLD_CYCLES+2 cycles.
REQ-018 Requester SHALL hold req and req_data stable until ack; a req still high after ack is treated as a new request.
REQ-019 out_data and grant_id SHALL retain their last values outside WRITE; out_en and ack SHALL be 0 outside WRITE.
REQ-020 Winner data SHALL be captured at the IDLE->WRITE edge; later req_data changes SHALL not affect out_data.

Reset
REQ-021 On reg_rst_n=0 at a clock edge, SHALL set out_data=0x00, out_en=0, ack=0, grant_id=0, busy=0, state=IDLE, hold counter=0, last=3 (requester 0 highest priority first).
REQ-022 Reset in WRITE or HOLD SHALL abort the operation immediately, with no further out_en or ack pulse.

Configuration
REQ-023 With OUTPUT_ARBITER_HOLD_EN defined, SHALL include the HOLD state and counter per REQ-015.
REQ-024 With OUTPUT_ARBITER_HOLD_EN undefined, SHALL omit HOLD and the counter; WRITE goes directly to IDLE; grant period = 2 cycles; HOLD_CYCLES ignored.

Verification
REQ-025 SHALL cover: reg_rst_n=0 for 2 cycles -> out_data=0x00, out_en=0, ack=0000, grant_id=0, busy=0.
REQ-026 SHALL cover: req=0100, req_data[23:16]=0xA5 -> next cycle out_en=1, ack=0100, out_data=0xA5, grant_id=2; busy high for 5 cycles (HOLD_CYCLES=4).
REQ-027 SHALL cover: req=1111 held continuously, HOLD_CYCLES=4 -> grants 0,1,2,3,0 spaced 6 cycles apart.
REQ-028 SHALL cover: after a grant to 1, req=1010 -> requester 3 granted before requester 1.
REQ-029 SHALL cover: reg_rst_n=0 during HOLD -> next cycle busy=0, no out_en; then req=1111 -> requester 0 granted first.
REQ-030 SHALL cover: OUTPUT_ARBITER_HOLD_EN undefined, req=1111 held -> out_en pulses every 2 cycles, grants 0,1,2,3.
